timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel countdown timer with prescaler, one-shot/periodic modes and a pause-wait engine. Second-generation replacement for Core18's single 12-bit timer: the core issues TIMER-style loads and PAUSE requests to it, and it returns per-channel status plus a registered STALL that holds the PC until the watched channel expires. It sits beside the core's decoder and drives the core's stall input.

## Interface
- WIDTH, 12, counter/reload width
- CHANNELS, 4, number of independent timers (power of two, ≥2)
- PRE_W, 8, prescaler width
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- CMD  in  2  per-cycle command: 00 none, 01 load one-shot, 10 load periodic, 11 stop
- SEL  in  log2(CHANNELS)  channel addressed by CMD
- VALUE  in  WIDTH  load value for CMD 01/10
- PRESCALE  in  PRE_W  tick period minus one (0 = tick every clock)
- PAUSE  in  1  pause request strobe (one cycle)
- PSEL  in  log2(CHANNELS)  channel watched by PAUSE
- ACK  in  CHANNELS  clear mask for STICKY
- RSEL  in  log2(CHANNELS)  readback channel
- ZERO  out  CHANNELS  counter == 0, registered
- EXPIRE  out  CHANNELS  one-cycle expiry pulse, registered
- STICKY  out  CHANNELS  latched expiry flags
- STALL  out  1  registered; 1 while a pause is waiting
- RDATA  out  WIDTH  combinational count[RSEL]

## Operation
- Reset: all counts 0, reloads 0, modes one-shot, ZERO all 1, EXPIRE 0, STICKY 0, STALL 0, prescaler count 0, pause FSM IDLE.
- Prescaler: shared down-counter; TICK=1 when count==0, then reload PRESCALE; else decrement. PRESCALE changes take effect at next reload.
- Load (CMD 01/10): count[SEL] <= VALUE, reload[SEL] <= VALUE, mode[SEL] set, ZERO[SEL] <= (VALUE==0). No EXPIRE on load. Load does not reset prescaler.
- On TICK, each non-loaded channel with count ≠ 0: count==1 → one-shot: count 0, ZERO 1; periodic: count <= reload (ZERO stays 0); both pulse EXPIRE and set STICKY. count >1 → decrement.
- Channels with count 0 hold (periodic with reload 0 never expires).
- Stop (CMD 11): count[SEL] <= 0, ZERO 1, mode one-shot, no EXPIRE, STICKY unchanged.
- CMD on a channel overrides its tick in that cycle.
- STICKY: set by expiry, cleared by ACK bit; simultaneous set and ACK → set wins.
- Pause FSM, states IDLE/WAIT, watched channel W latched from PSEL:
  - IDLE + PAUSE: if next-state ZERO[PSEL]==1 → stay IDLE, STALL 0; else → WAIT, STALL <= 1.
  - WAIT: exit to IDLE, STALL <= 0, on edge where channel W's next ZERO==1 or its EXPIRE fires (covers stop, load 0, periodic expiry).
  - Load of nonzero value to W while WAIT: keep waiting on new value.
  - PAUSE while WAIT: ignored.
- RESET mid-operation returns everything to reset values in one edge, including STALL.

## Timing
- Load at edge k: count/ZERO valid after k; first decrement at first TICK edge after k.
- PRESCALE=0: load N at edge k, count reaches 0 at edge k+N, ZERO and EXPIRE high after k+N, EXPIRE low after k+N+1.
- PRESCALE=P: one decrement every P+1 clocks.
- STALL rises the edge PAUSE is sampled; falls on the same edge EXPIRE/ZERO of W rises. Stalled cycles for PRESCALE=0, remaining count C: C.
- Periodic period (PRESCALE=0, reload R): EXPIRE every R clocks.

## Test plan
- Reset, then CMD 01 VALUE 8 SEL 0, PRESCALE 0 → count 8,7,…,0 one per clock; ZERO[0] and EXPIRE[0] rise after 8th edge; EXPIRE one cycle; STICKY[0] 1 until ACK[0].
- CMD 10 VALUE 3 SEL 2 → EXPIRE[2] every 3 clocks, count cycles 3,2,1,3; ZERO[2] stays 0; CMD 11 → count 0, ZERO 1, no pulse.
- PRESCALE 3, load 2 on ch1 → decrements every 4 clocks, expiry 8 clocks after load (±prescaler phase ≤3).
- Load 4 on ch0 then PAUSE PSEL 0 next cycle → STALL high exactly 3 cycles, falls with ZERO[0]; PAUSE on ch with ZERO=1 → STALL never rises.
- Simultaneous: load ch1 on its expiring tick → load wins, no EXPIRE; ACK[1] same cycle as expiry → STICKY[1] 1; load 0 to watched ch in WAIT → STALL falls next edge.
- RESET asserted during WAIT with counters running → next edge STALL 0, all counts 0, ZERO all 1, STICKY 0.

Source files
------------

// File: rtl/timer_bank.sv
// timer_bank: bank of countdown timers sharing one prescaler, with
// one-shot/periodic reload and a pause engine that stalls the core
// until a watched channel reaches zero or expires.
//
// Handshake note: there is no valid/ready flow control. CMD, PAUSE and ACK
// are single-cycle strobes sampled on every rising CLK edge, and each takes
// effect on the edge that samples it. STALL is the only back-pressure
// signal. It is registered, it rises on the edge that accepts a PAUSE, and
// it falls on the edge where the watched channel's ZERO or EXPIRE rises.
module timer_bank #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int PRE_W    = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [1:0]                  CMD,
  input  logic [$clog2(CHANNELS)-1:0] SEL,
  input  logic [WIDTH-1:0]            VALUE,
  input  logic [PRE_W-1:0]            PRESCALE,
  input  logic                        PAUSE,
  input  logic [$clog2(CHANNELS)-1:0] PSEL,
  input  logic [CHANNELS-1:0]         ACK,
  input  logic [$clog2(CHANNELS)-1:0] RSEL,
  output logic [CHANNELS-1:0]         ZERO,
  output logic [CHANNELS-1:0]         EXPIRE,
  output logic [CHANNELS-1:0]         STICKY,
  output logic                        STALL,
  output logic [WIDTH-1:0]            RDATA,
  output logic                        dbg_state
);

  localparam int SW = $clog2(CHANNELS);

  localparam logic [1:0] CMD_NONE     = 2'b00;
  localparam logic [1:0] CMD_ONESHOT  = 2'b01;
  localparam logic [1:0] CMD_PERIODIC = 2'b10;
  localparam logic [1:0] CMD_STOP     = 2'b11;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} pause_state_t;

  logic [PRE_W-1:0]    pre_q;
  logic                tick;
  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [CHANNELS-1:0] mode_q;   // 1 = periodic
  logic [WIDTH-1:0]    cnt_n    [CHANNELS];
  logic [WIDTH-1:0]    reload_n [CHANNELS];
  logic [CHANNELS-1:0] mode_n;
  logic [CHANNELS-1:0] zero_n;
  logic [CHANNELS-1:0] exp_n;
  logic [CHANNELS-1:0] sticky_n;
  pause_state_t        state_q, state_n;
  logic [SW-1:0]       w_q, w_n;

  assign tick      = (pre_q == '0);
  assign RDATA     = cnt_q[RSEL];
  assign dbg_state = state_q;

  // Shared prescaler: tick on zero, then reload the (possibly new) period.
  always_ff @(posedge CLK) begin
    if (RESET)     pre_q <= '0;
    else if (tick) pre_q <= PRESCALE;
    else           pre_q <= pre_q - 1'b1;
  end

  // Per-channel next state; a command on a channel overrides its tick.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_n[i]    = cnt_q[i];
      reload_n[i] = reload_q[i];
      mode_n[i]   = mode_q[i];
      exp_n[i]    = 1'b0;
      if (CMD != CMD_NONE && SEL == SW'(i)) begin
        if (CMD == CMD_STOP) begin
          cnt_n[i]  = '0;
          mode_n[i] = 1'b0;
        end else begin
          cnt_n[i]    = VALUE;
          reload_n[i] = VALUE;
          mode_n[i]   = (CMD == CMD_PERIODIC);
        end
      end else if (tick && cnt_q[i] != '0) begin
        if (cnt_q[i] == WIDTH'(1)) begin
          exp_n[i] = 1'b1;
          cnt_n[i] = mode_q[i] ? reload_q[i] : '0;
        end else begin
          cnt_n[i] = cnt_q[i] - 1'b1;
        end
      end
      zero_n[i]   = (cnt_n[i] == '0);
      sticky_n[i] = exp_n[i] | (STICKY[i] & ~ACK[i]);
    end
  end

  // Channel registers and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
      end
      mode_q <= '0;
      ZERO   <= '1;
      EXPIRE <= '0;
      STICKY <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= cnt_n[i];
        reload_q[i] <= reload_n[i];
      end
      mode_q <= mode_n;
      ZERO   <= zero_n;
      EXPIRE <= exp_n;
      STICKY <= sticky_n;
    end
  end

  // Pause FSM next state: enter WAIT only if the watched channel is not
  // already at zero; leave on its zero or expiry (covers periodic wrap).
  always_comb begin
    state_n = state_q;
    w_n     = w_q;
    case (state_q)
      IDLE: begin
        if (PAUSE && !zero_n[PSEL]) begin
          state_n = WAIT;
          w_n     = PSEL;
        end
      end
      WAIT: begin
        if (zero_n[w_q] || exp_n[w_q]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pause FSM state register; STALL mirrors the next state so it is registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      w_q     <= '0;
      STALL   <= 1'b0;
    end else begin
      state_q <= state_n;
      w_q     <= w_n;
      STALL   <= (state_n == WAIT);
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: table-driven per-cycle vectors for timer_bank plus a
// hand-written periodic-interval sequence.
module tb_timer_bank;

  logic        CLK;
  logic        RESET;
  logic [1:0]  CMD;
  logic [1:0]  SEL;
  logic [11:0] VALUE;
  logic [7:0]  PRESCALE;
  logic        PAUSE;
  logic [1:0]  PSEL;
  logic [3:0]  ACK;
  logic [1:0]  RSEL;
  logic [3:0]  ZERO;
  logic [3:0]  EXPIRE;
  logic [3:0]  STICKY;
  logic        STALL;
  logic [11:0] RDATA;
  logic        dbg_state;

  int tests  = 0;
  int errors = 0;

  timer_bank #(.WIDTH(12), .CHANNELS(4), .PRE_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .CMD(CMD), .SEL(SEL), .VALUE(VALUE),
    .PRESCALE(PRESCALE), .PAUSE(PAUSE), .PSEL(PSEL), .ACK(ACK), .RSEL(RSEL),
    .ZERO(ZERO), .EXPIRE(EXPIRE), .STICKY(STICKY), .STALL(STALL),
    .RDATA(RDATA), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [1:0]  cmd;
    logic [1:0]  sel;
    logic [11:0] value;
    logic [7:0]  pre;
    logic        pause;
    logic [1:0]  psel;
    logic [3:0]  ack;
    logic [1:0]  rsel;
    logic [11:0] e_rdata;
    logic [3:0]  e_zero;
    logic [3:0]  e_exp;
    logic [3:0]  e_sticky;
    logic        e_stall;
  } vec_t;

  vec_t vq[$];
  // scoreboard: expected {rdata, zero, expire, sticky, stall} per vector
  logic [24:0] exp_q[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] cmd, input logic [1:0] sel,
                              input logic [11:0] value, input logic [7:0] pre, input logic pause,
                              input logic [1:0] psel, input logic [3:0] ack, input logic [1:0] rsel,
                              input logic [11:0] rd, input logic [3:0] z, input logic [3:0] e,
                              input logic [3:0] s, input logic st);
    vec_t v;
    v.rst = rst; v.cmd = cmd; v.sel = sel; v.value = value; v.pre = pre;
    v.pause = pause; v.psel = psel; v.ack = ack; v.rsel = rsel;
    v.e_rdata = rd; v.e_zero = z; v.e_exp = e; v.e_sticky = s; v.e_stall = st;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    RESET = v.rst; CMD = v.cmd; SEL = v.sel; VALUE = v.value; PRESCALE = v.pre;
    PAUSE = v.pause; PSEL = v.psel; ACK = v.ack; RSEL = v.rsel;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, req);
    end
  endtask

  initial begin
    logic [24:0] e;
    int n;
    vec_t idle_v;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hf, 0, 0, 0));

    // Scenario 1: one-shot 8 on ch0, sticky until ACK
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hf, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 8, 0, 0, 0, 0, 0, 8, 4'he, 0, 0, 0));
    for (int k = 7; k >= 1; k--) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'(k), 4'he, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hf, 4'h1, 4'h1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hf, 0, 4'h1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h1, 0, 0, 4'hf, 0, 0, 0));
    // Scenario 2: periodic 3 on ch2, then stop
    vq.push_back(mk(0, 2, 2, 3, 0, 0, 0, 0, 2, 3, 4'hb, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 4'hb, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 4'hb, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 4'hb, 4'h4, 4'h4, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 4'hb, 0, 4'h4, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 4'hb, 0, 4'h4, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 4'hb, 4'h4, 4'h4, 0));
    vq.push_back(mk(0, 3, 2, 0, 0, 0, 0, 0, 2, 0, 4'hf, 0, 4'h4, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h4, 2, 0, 4'hf, 0, 0, 0));
    // Scenario 3: PRESCALE 3, load 2 on ch1; ACK on the expiry edge loses to set
    vq.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0, 1, 0, 4'hf, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 2, 3, 0, 0, 0, 1, 2, 4'hd, 0, 0, 0));
    for (int k = 0; k < 3; k++) vq.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 1, 2, 4'hd, 0, 0, 0));
    for (int k = 0; k < 4; k++) vq.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 4'hd, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 3, 0, 0, 4'h2, 1, 0, 4'hf, 4'h2, 4'h2, 0));
    vq.push_back(mk(0, 0, 0, 0, 3, 0, 0, 4'h2, 1, 0, 4'hf, 0, 0, 0));
    // Scenario 4: pause on ch0 with 4 loaded, then pause on zero channels
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hf, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 4, 0, 0, 0, 0, 0, 4, 4'he, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 4'he, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4'he, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'he, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hf, 4'h1, 4'h1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'hf, 0, 4'h1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'hf, 0, 4'h1, 0));
    // Scenario 5: load wins over expiring tick; reload and load 0 during WAIT
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hf, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 1, 2, 4'hd, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'hd, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 1, 5, 4'hd, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 4, 4'hd, 0, 0, 1));
    vq.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 1, 2, 4'hd, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 4'hd, 0, 0, 1));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 4'hf, 0, 0, 0));
    // Scenario 6: reset during WAIT with counters running and sticky set
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hf, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 9, 0, 0, 0, 0, 0, 9, 4'he, 0, 0, 0));
    vq.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 8, 4'h6, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 7, 4'he, 4'h8, 4'h8, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 4'he, 0, 4'h8, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hf, 0, 0, 0));

    foreach (vq[i]) exp_q.push_back({vq[i].e_rdata, vq[i].e_zero, vq[i].e_exp, vq[i].e_sticky, vq[i].e_stall});

    #2;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      step();
      e = exp_q.pop_front();
      check("rdata",  i, 32'(RDATA),  32'(e[24:13]));
      check("zero",   i, 32'(ZERO),   32'(e[12:9]));
      check("expire", i, 32'(EXPIRE), 32'(e[8:5]));
      check("sticky", i, 32'(STICKY), 32'(e[4:1]));
      check("stall",  i, 32'(STALL),  32'(e[0]));
    end

    // Hand sequence: periodic reload 5 on ch1 pulses EXPIRE every 5 clocks
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(mk(0, 2, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step();
    drive(idle_v);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!EXPIRE[1] && n < 20);
      check("period", p, 32'(n), 32'd5);
      check("period_zero", p, 32'(ZERO[1]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
